// File: rtl/tspp_hazard_control.sv
// Hazard and trap-sequencing controller for the two-stage fetch/execute pipeline.
// Resolves memory stalls and control-flow redirects, and sequences precise traps
// and xRETs through a request/insert handshake with the privilege unit.
module tspp_hazard_control (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        i_ram_busy,
  input  logic        iren,
  input  logic        d_ram_busy,
  input  logic        dren,
  input  logic        dwen,
  input  logic        jump,
  input  logic        branch,
  input  logic        mispredict,
  input  logic        halt,
  input  logic        fault_insn,
  input  logic        mal_insn,
  input  logic        illegal_insn,
  input  logic        breakpoint,
  input  logic        env_m,
  input  logic        mal_l,
  input  logic        fault_l,
  input  logic        mal_s,
  input  logic        fault_s,
  input  logic        interrupt,
  input  logic        ret,
  input  logic [31:0] pc,
  input  logic        insert_pc,
  output logic        pc_en,
  output logic        npc_sel,
  output logic        if_ex_stall,
  output logic        if_ex_flush,
  output logic        prv_req,
  output logic        prv_intr,
  output logic        prv_ret,
  output logic [3:0]  prv_cause,
  output logic [31:0] prv_epc
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DRAIN  = 2'd1,
    TRAP   = 2'd2,
    HALTED = 2'd3
  } state_t;

  state_t      state, state_next;
  logic        exc, dwait, iwait, redirect, trap_evt;
  logic [3:0]  cause_next;

  assign exc      = fault_insn | mal_insn | illegal_insn | breakpoint | env_m |
                    mal_l | fault_l | mal_s | fault_s;
  assign dwait    = (dren | dwen) & d_ram_busy;
  assign iwait    = iren & i_ram_busy;
  assign redirect = jump | (branch & mispredict);
  assign trap_evt = exc | interrupt | ret;

  // Fixed-priority exception cause encoder; zero when only an interrupt or xRET is pending.
  always_comb begin
    // NOTE: default assignment first so every path drives cause_next and no latch is inferred.
    cause_next = 4'd0;
    if      (fault_insn)   cause_next = 4'd1;
    else if (mal_insn)     cause_next = 4'd0;
    else if (illegal_insn) cause_next = 4'd2;
    else if (breakpoint)   cause_next = 4'd3;
    else if (env_m)        cause_next = 4'd11;
    else if (mal_l)        cause_next = 4'd4;
    else if (fault_l)      cause_next = 4'd5;
    else if (mal_s)        cause_next = 4'd6;
    else if (fault_s)      cause_next = 4'd7;
  end

  // State register.
  always_ff @(posedge CLK or negedge nRST) begin
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    if (!nRST) state <= RUN;
    else       state <= state_next;
  end

  // Next-state logic: events win over halt; the drain waits for both memories to go idle.
  always_comb begin
    state_next = state;
    unique case (state)
      RUN: begin
        if (trap_evt)  state_next = (dwait | iwait) ? DRAIN : TRAP;
        else if (halt) state_next = HALTED;
      end
      DRAIN:  if (!d_ram_busy && !i_ram_busy) state_next = TRAP;
      TRAP:   if (insert_pc) state_next = RUN;
      HALTED: state_next = HALTED;
      default: state_next = RUN;
    endcase
  end

  // Output decode: stall and pc_en are complements in every state.
  always_comb begin
    pc_en       = 1'b1;
    npc_sel     = 1'b0;
    if_ex_stall = 1'b0;
    if_ex_flush = 1'b0;
    unique case (state)
      RUN: begin
        if (trap_evt) begin
          if_ex_stall = 1'b1;
          pc_en       = 1'b0;
        end else begin
          if_ex_stall = dwait | iwait;
          pc_en       = !(dwait | iwait);
          npc_sel     = redirect;
          // The wrong-path fetch is killed even while the fetch memory is busy.
          if_ex_flush = redirect & !dwait;
        end
      end
      DRAIN: begin
        if_ex_stall = 1'b1;
        pc_en       = 1'b0;
      end
      TRAP: begin
        if (insert_pc) begin
          pc_en       = 1'b1;
          npc_sel     = 1'b1;
          if_ex_flush = 1'b1;
          if_ex_stall = 1'b0;
        end else begin
          pc_en       = 1'b0;
          if_ex_stall = 1'b1;
        end
      end
      HALTED: begin
        pc_en       = 1'b0;
        if_ex_stall = 1'b1;
        if_ex_flush = 1'b1;
      end
      default: begin
        pc_en       = 1'b1;
      end
    endcase
  end

  // Trap capture and registered request; captured values hold until the next event in RUN.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      prv_req   <= 1'b0;
      prv_intr  <= 1'b0;
      prv_ret   <= 1'b0;
      prv_cause <= 4'd0;
      prv_epc   <= 32'd0;
    end else begin
      prv_req <= (state_next == TRAP);
      if (state == RUN && trap_evt) begin
        prv_epc   <= pc;
        prv_cause <= cause_next;
        prv_intr  <= interrupt & !exc & !ret;
        prv_ret   <= ret & !exc;
      end
    end
  end

endmodule

// File: tb/tb_tspp_hazard_control.sv
// Directed bench for tspp_hazard_control: expectations are queued when stimulus is
// applied and popped against the DUT outputs once they settle.
module tb_tspp_hazard_control;

  logic        CLK, nRST;
  logic        i_ram_busy, iren, d_ram_busy, dren, dwen;
  logic        jump, branch, mispredict, halt;
  logic        fault_insn, mal_insn, illegal_insn, breakpoint, env_m;
  logic        mal_l, fault_l, mal_s, fault_s;
  logic        interrupt, ret, insert_pc;
  logic [31:0] pc;
  logic        pc_en, npc_sel, if_ex_stall, if_ex_flush;
  logic        prv_req, prv_intr, prv_ret;
  logic [3:0]  prv_cause;
  logic [31:0] prv_epc;

  tspp_hazard_control dut (
    .CLK(CLK), .nRST(nRST),
    .i_ram_busy(i_ram_busy), .iren(iren),
    .d_ram_busy(d_ram_busy), .dren(dren), .dwen(dwen),
    .jump(jump), .branch(branch), .mispredict(mispredict), .halt(halt),
    .fault_insn(fault_insn), .mal_insn(mal_insn), .illegal_insn(illegal_insn),
    .breakpoint(breakpoint), .env_m(env_m), .mal_l(mal_l), .fault_l(fault_l),
    .mal_s(mal_s), .fault_s(fault_s),
    .interrupt(interrupt), .ret(ret), .pc(pc), .insert_pc(insert_pc),
    .pc_en(pc_en), .npc_sel(npc_sel), .if_ex_stall(if_ex_stall), .if_ex_flush(if_ex_flush),
    .prv_req(prv_req), .prv_intr(prv_intr), .prv_ret(prv_ret),
    .prv_cause(prv_cause), .prv_epc(prv_epc)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    string       tag;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  task automatic push(input string tag, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic check(input logic [31:0] obs);
    exp_t e;
    n_assert++;
    if (sb.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %h required <none>", obs);
    end else begin
      e = sb.pop_front();
      assert (obs === e.val) else begin
        n_fail++;
        $error("FAIL %s: observed %h required %h", e.tag, obs, e.val);
      end
    end
  endtask

  task automatic expect_ctl(input string tag, input logic pe, input logic ns,
                            input logic st, input logic fl);
    push({tag, ".pc_en"}, {31'd0, pe});
    push({tag, ".npc_sel"}, {31'd0, ns});
    push({tag, ".if_ex_stall"}, {31'd0, st});
    push({tag, ".if_ex_flush"}, {31'd0, fl});
  endtask

  task automatic sample_ctl();
    check({31'd0, pc_en});
    check({31'd0, npc_sel});
    check({31'd0, if_ex_stall});
    check({31'd0, if_ex_flush});
  endtask

  task automatic expect_prv(input string tag, input logic rq, input logic it,
                            input logic rt, input logic [3:0] cs, input logic [31:0] ep);
    push({tag, ".prv_req"}, {31'd0, rq});
    push({tag, ".prv_intr"}, {31'd0, it});
    push({tag, ".prv_ret"}, {31'd0, rt});
    push({tag, ".prv_cause"}, {28'd0, cs});
    push({tag, ".prv_epc"}, ep);
  endtask

  task automatic sample_prv();
    check({31'd0, prv_req});
    check({31'd0, prv_intr});
    check({31'd0, prv_ret});
    check({28'd0, prv_cause});
    check(prv_epc);
  endtask

  task automatic idle();
    i_ram_busy = 0; iren = 0; d_ram_busy = 0; dren = 0; dwen = 0;
    jump = 0; branch = 0; mispredict = 0; halt = 0;
    fault_insn = 0; mal_insn = 0; illegal_insn = 0; breakpoint = 0; env_m = 0;
    mal_l = 0; fault_l = 0; mal_s = 0; fault_s = 0;
    interrupt = 0; ret = 0; insert_pc = 0; pc = 32'h0;
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Finish a trap sequence already in TRAP: pulse insert_pc, then confirm prv_req drops.
  task automatic finish_trap(input string tag);
    insert_pc = 1'b1;
    #1;
    expect_ctl({tag, "_ins"}, 1, 1, 0, 1); sample_ctl();
    push({tag, "_ins.prv_req"}, 32'd1); check({31'd0, prv_req});
    tick();
    insert_pc = 1'b0;
    #1;
    push({tag, "_after.prv_req"}, 32'd0); check({31'd0, prv_req});
    expect_ctl({tag, "_after"}, 1, 0, 0, 0); sample_ctl();
  endtask

  initial begin
    idle();
    nRST = 1'b0;
    #12;
    // Reset state
    expect_prv("reset", 0, 0, 0, 4'd0, 32'h0); sample_prv();
    expect_ctl("reset", 1, 0, 0, 0); sample_ctl();
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Mispredicted branch: zero-latency redirect
    branch = 1; mispredict = 1;
    #1;
    expect_ctl("mispredict", 1, 1, 0, 1); sample_ctl();
    tick();
    // Jump during fetch wait: still flushed
    idle(); jump = 1; iren = 1; i_ram_busy = 1;
    #1;
    expect_ctl("jump_iwait", 0, 1, 1, 1); sample_ctl();
    tick();
    // Jump during data wait: no flush
    idle(); jump = 1; dwen = 1; d_ram_busy = 1;
    #1;
    expect_ctl("jump_dwait", 0, 1, 1, 0); sample_ctl();
    tick();
    // insert_pc outside TRAP is ignored
    idle(); insert_pc = 1;
    #1;
    expect_ctl("stray_insert", 1, 0, 0, 0); sample_ctl();
    tick();

    // Load with d_ram_busy for exactly 3 cycles
    idle(); dren = 1; d_ram_busy = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_ctl($sformatf("load_busy%0d", i), 0, 0, 1, 0); sample_ctl();
      tick();
    end
    d_ram_busy = 0;
    #1;
    expect_ctl("load_done", 1, 0, 0, 0); sample_ctl();
    tick();

    // illegal_insn at 0x100, no busy
    idle(); illegal_insn = 1; pc = 32'h0000_0100;
    #1;
    expect_ctl("illegal_evt", 0, 0, 1, 0); sample_ctl();
    tick();
    idle(); pc = 32'h0000_0200; fault_s = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      expect_prv($sformatf("illegal_trap%0d", i), 1, 0, 0, 4'd2, 32'h100); sample_prv();
      expect_ctl($sformatf("illegal_trap%0d", i), 0, 0, 1, 0); sample_ctl();
      tick();
    end
    fault_s = 0;
    finish_trap("illegal");
    tick();

    // mal_l + interrupt + jump while data memory busy for 2 cycles
    idle(); mal_l = 1; interrupt = 1; jump = 1; dren = 1; d_ram_busy = 1; pc = 32'h0000_0300;
    #1;
    expect_ctl("mal_l_evt", 0, 0, 1, 0); sample_ctl();
    tick();
    idle(); d_ram_busy = 1; fault_insn = 1; pc = 32'h0000_0400;
    #1;
    expect_prv("drain0", 0, 0, 0, 4'd4, 32'h300); sample_prv();
    expect_ctl("drain0", 0, 0, 1, 0); sample_ctl();
    tick();
    idle();
    #1;
    push("drain1.prv_req", 32'd0); check({31'd0, prv_req});
    expect_ctl("drain1", 0, 0, 1, 0); sample_ctl();
    tick();
    #1;
    expect_prv("mal_l_trap", 1, 0, 0, 4'd4, 32'h300); sample_prv();
    finish_trap("mal_l");
    tick();

    // xRET together with interrupt: xRET wins
    idle(); ret = 1; interrupt = 1; pc = 32'h0000_0500;
    tick();
    idle();
    #1;
    expect_prv("ret_trap", 1, 0, 1, 4'd0, 32'h500); sample_prv();
    finish_trap("ret");
    tick();

    // Interrupt alone
    idle(); interrupt = 1; pc = 32'h0000_0600;
    tick();
    idle();
    #1;
    expect_prv("intr_trap", 1, 1, 0, 4'd0, 32'h600); sample_prv();
    finish_trap("intr");
    tick();

    // breakpoint outranks env_m; env_m outranks fault_s
    idle(); env_m = 1; fault_s = 1; breakpoint = 1; pc = 32'h0000_0700;
    tick();
    idle();
    #1;
    expect_prv("bkpt_trap", 1, 0, 0, 4'd3, 32'h700); sample_prv();
    finish_trap("bkpt");
    tick();
    idle(); env_m = 1; fault_s = 1; ret = 1; pc = 32'h0000_0800;
    tick();
    idle();
    #1;
    expect_prv("ecall_trap", 1, 0, 0, 4'd11, 32'h800); sample_prv();
    finish_trap("ecall");
    tick();

    // halt: locked until reset
    idle(); halt = 1;
    #1;
    expect_ctl("halt_cycle", 1, 0, 0, 0); sample_ctl();
    tick();
    idle(); insert_pc = 1; illegal_insn = 1; pc = 32'h0000_0900;
    for (int i = 0; i < 3; i++) begin
      #1;
      expect_ctl($sformatf("halted%0d", i), 0, 0, 1, 1); sample_ctl();
      push($sformatf("halted%0d.prv_req", i), 32'd0); check({31'd0, prv_req});
      tick();
    end
    idle();
    #2;
    nRST = 1'b0;
    #1;
    expect_ctl("halt_reset", 1, 0, 0, 0); sample_ctl();
    @(negedge CLK);
    nRST = 1'b1;
    tick();

    // Reset pulsed in the middle of a trap
    idle(); illegal_insn = 1; pc = 32'h0000_0444;
    tick();
    idle();
    #1;
    expect_prv("pre_abort", 1, 0, 0, 4'd2, 32'h444); sample_prv();
    #1;
    nRST = 1'b0;
    #1;
    expect_prv("abort", 0, 0, 0, 4'd0, 32'h0); sample_prv();
    @(negedge CLK);
    nRST = 1'b1;
    tick();
    #1;
    expect_ctl("post_abort", 1, 0, 0, 0); sample_ctl();

    // Every queued expectation must have been consumed.
    n_assert++;
    assert (sb.size() == 0) else begin
      n_fail++;
      $error("FAIL scoreboard_leftover: observed %0d entries required 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/tspp_hazard_control.md
# tspp_hazard_control

Hazard and trap-sequencing controller for the two-stage (fetch / execute) pipeline. It drives the fetch and execute stages through the hazard unit interface. It consumes memory-busy, control-flow and exception flags from both stages and resolves memory stalls and branch/jump redirects. It sequences precise traps through a request/insert handshake with the privilege unit.

## Interface
- No parameters.
- CLK  in  1  pipeline clock, rising edge.
- nRST  in  1  asynchronous active-low reset.
- i_ram_busy, iren  in  1 each  fetch memory busy / fetch read enable.
- d_ram_busy, dren, dwen  in  1 each  data memory busy / read / write enables.
- jump, branch, mispredict  in  1 each  execute-stage control flow.
- halt  in  1  execute-stage halt instruction.
- fault_insn, mal_insn, illegal_insn, breakpoint, env_m, mal_l, fault_l, mal_s, fault_s  in  1 each  pipeline exception flags.
- interrupt  in  1  pending enabled interrupt from privilege unit.
- ret  in  1  execute-stage xRET.
- pc  in  32  execute-stage instruction PC.
- insert_pc  in  1  privilege unit has placed the trap/return vector on the next-PC path.
- pc_en, npc_sel, if_ex_stall, if_ex_flush  out  1 each  fetch/execute control.
- prv_req  out  1  trap/return request to privilege unit.
- prv_intr, prv_ret  out  1 each  request is an interrupt / an xRET.
- prv_cause  out  4  exception cause code.
- prv_epc  out  32  captured faulting PC.

## Operation
- Derived terms:
  - exc = OR of the nine exception flags.
  - dwait = (dren|dwen)&d_ram_busy.
  - iwait = iren&i_ram_busy.
  - redirect = jump|(branch&mispredict).
- States: RUN, DRAIN, TRAP, HALTED. Reset state is RUN.
- RUN, no event:
  - if_ex_stall = dwait|iwait.
  - pc_en = !if_ex_stall.
  - npc_sel = redirect.
  - if_ex_flush = redirect & !dwait. The wrong-path fetch is killed even while iwait is asserted.
- RUN, event = exc|interrupt|ret:
  - Asserts if_ex_stall=1, pc_en=0, npc_sel=0.
  - Captures prv_epc=pc.
  - Captures prv_cause by fixed priority with these codes: fault_insn 1, mal_insn 0, illegal_insn 2, breakpoint 3, env_m 11, mal_l 4, fault_l 5, mal_s 6, fault_s 7.
  - Captures prv_intr = interrupt&!exc&!ret.
  - Captures prv_ret = ret&!exc.
  - Priority: exc > ret > interrupt. The cause is 0 when there is no exc.
  - Next state: DRAIN if dwait|iwait, else TRAP.
- Ordering within RUN: an event overrides a redirect in the same cycle. halt with no event moves to HALTED.
- DRAIN:
  - if_ex_stall=1, pc_en=0, if_ex_flush=0.
  - Moves to TRAP on the first cycle where d_ram_busy=0 and i_ram_busy=0.
  - New exception flags are ignored; captured values hold.
- TRAP:
  - prv_req=1 and if_ex_stall=1.
  - pc_en=0 until insert_pc=1.
  - In the insert_pc cycle: pc_en=1, npc_sel=1, if_ex_flush=1, if_ex_stall=0. The next state is RUN.
- HALTED: pc_en=0, if_ex_stall=1, if_ex_flush=1, npc_sel=0. The only exit is reset.
- insert_pc outside TRAP is ignored.
- Reset values:
  - Registers: state RUN, prv_req 0, prv_intr 0, prv_ret 0, prv_cause 0, prv_epc 0.
  - Combinational outputs with idle inputs: pc_en 1, npc_sel 0, if_ex_stall 0, if_ex_flush 0.
- nRST low mid-trap aborts the sequence. prv_req drops immediately (asynchronously).

## Timing
- Event sampled in RUN at cycle N → prv_req=1 from N+1 when no memory is busy. Otherwise it asserts one cycle after both busy signals fall.
- prv_req is registered (not decoded from inputs). It stays high through the insert_pc cycle and is low the cycle after.
- prv_cause, prv_epc, prv_intr and prv_ret are stable from N+1 until the next event capture.
- Redirect has 0-cycle latency (combinational npc_sel/if_ex_flush in the redirect cycle).
- pc_en and if_ex_stall are mutually exclusive in every state and cycle.

## Test plan
- Mispredicted branch (branch=1, mispredict=1, no busy) → same cycle: npc_sel=1, if_ex_flush=1, pc_en=1, if_ex_stall=0.
- Load with d_ram_busy=1 for 3 cycles → if_ex_stall=1 and pc_en=0 for exactly 3 cycles, then pc_en=1.
- illegal_insn with pc=0x0000_0100, no busy → next cycle prv_req=1, prv_cause=2, prv_epc=0x100. Hold insert_pc=0 for 4 cycles (pc_en=0), then pulse it → that cycle pc_en=1, npc_sel=1, if_ex_flush=1; the following cycle prv_req=0.
- mal_l, interrupt and jump in the same cycle with d_ram_busy=1 for 2 cycles:
  - Expect prv_cause=4, prv_intr=0, npc_sel=0.
  - Expect 2 cycles of DRAIN, then prv_req=1.
- halt=1 → pc_en=0, if_ex_stall=1 on every later cycle, with insert_pc and exceptions ignored. Asserting nRST=0 returns to RUN with pc_en=1.
- nRST pulsed low while in TRAP → prv_req=0, prv_cause=0, prv_epc=0 immediately.
